// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router packet transmitter slice.
//   - Field widths for address, length and data bytes
//   - Transmit FSM state encoding
//   - Header packing and parity accumulation helpers
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int LEN_W     = 6;
    localparam int DATA_W    = 8;
    localparam int MAX_LEN   = 63;
    localparam int BUF_DEPTH = MAX_LEN + 1;
    localparam int PTR_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_PARITY  = 3'd4,
        ST_GAP     = 3'd5
    } tx_state_e;

    // Header byte carries the length in the upper six bits, address below.
    function automatic logic [DATA_W-1:0] hdr_pack(
        input logic [LEN_W-1:0]  len,
        input logic [ADDR_W-1:0] addr
    );
        return {len, addr};
    endfunction

    // Running XOR parity over every byte sent on the router side.
    function automatic logic [DATA_W-1:0] parity_update(
        input logic [DATA_W-1:0] parity,
        input logic [DATA_W-1:0] data
    );
        return parity ^ data;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// -----------------------------------------------------------------------------
// router_tx_buf
// 64x8 payload buffer: one write port, one read port, registered read data.
// The read register always holds mem[read pointer], including the case where
// that entry is being written on the same edge, so the transmitter can launch
// the next byte on the edge the current one is consumed.
//
// Ports:
//   clock, reset  : clock, synchronous active-high reset
//   i_clr         : synchronous clear of both pointers
//   i_wr_en       : write i_wr_data at the write pointer, then advance it
//   i_wr_data     : byte to store
//   i_rd_inc      : advance the read pointer
//   o_wr_ptr      : current write pointer
//   o_rd_ptr      : current read pointer
//   o_rd_data     : registered copy of mem[o_rd_ptr]
// -----------------------------------------------------------------------------
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_inc,
    output logic [PTR_W-1:0]  o_wr_ptr,
    output logic [PTR_W-1:0]  o_rd_ptr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_rd_data;
    logic [PTR_W-1:0]  w_rd_next;
    logic              w_bypass;

    // Read pointer value after this edge; the read register follows it.
    always_comb begin
        w_rd_next = r_rd_ptr;
        if (i_clr) begin
            w_rd_next = {PTR_W{1'b0}};
        end else if (i_rd_inc) begin
            w_rd_next = r_rd_ptr + PTR_W'(1);
        end else begin
            w_rd_next = r_rd_ptr;
        end
    end

    // Forward the write data when it lands on the entry about to be read.
    assign w_bypass = i_wr_en && (r_wr_ptr == w_rd_next);

    // Pointer and read-data registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr  <= {PTR_W{1'b0}};
            r_rd_ptr  <= {PTR_W{1'b0}};
            r_rd_data <= {DATA_W{1'b0}};
        end else begin
            if (i_clr) begin
                r_wr_ptr <= {PTR_W{1'b0}};
            end else if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            r_rd_ptr  <= w_rd_next;
            r_rd_data <= w_bypass ? i_wr_data : r_mem[w_rd_next];
        end
    end

    // Storage array write port; contents need no reset.
    always_ff @(posedge clock) begin
        if (!reset && i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_wr_ptr  = r_wr_ptr;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/router_pkt_tx.sv
// -----------------------------------------------------------------------------
// router_pkt_tx
// Packet transmitter feeding the router input port. A descriptor (address,
// length) is accepted, the whole payload is buffered, then header, payload
// and parity are driven on pkt_valid/data_in while honouring busy. A gap of
// GAP_CYCLES idle cycles (0..15) follows each packet.
//
// Optional feature macro: ROUTER_PKT_TX_ERR_INJECT_EN
//   When defined, input inject_err is sampled at request accept and, if set,
//   the transmitted parity byte is inverted.
//
// Ports:
//   clock, reset        : clock, synchronous active-high reset
//   req_valid/req_ready : descriptor handshake (req_addr, req_len)
//   pl_valid/pl_ready   : payload byte handshake (pl_data)
//   busy                : router back-pressure; byte on data_in held while 1
//   pkt_valid, data_in  : router-side byte stream (pkt_valid low on parity)
//   tx_active           : high from request accept to end of gap
//   tx_done             : one-cycle pulse after the parity byte is consumed
//   inject_err          : (macro only) invert parity of this packet
// -----------------------------------------------------------------------------
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic              req_ready,
    input  logic              pl_valid,
    input  logic [DATA_W-1:0] pl_data,
    output logic              pl_ready,
    input  logic              busy,
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_in,
    output logic              tx_active,
    output logic              tx_done
);

    localparam logic [3:0] GAP_VAL = 4'(GAP_CYCLES);

    tx_state_e         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_parity;
    logic [3:0]        r_gap_cnt;
    logic              r_pkt_valid;
    logic [DATA_W-1:0] r_data_in;
    logic              r_tx_active;
    logic              r_tx_done;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    logic              r_inject;
`endif

    logic              w_accept;
    logic              w_wr_en;
    logic              w_rd_inc;
    logic              w_last_wr;
    logic              w_last_rd;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_parity_out;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_wr_en  = (r_state == ST_LOAD) && pl_valid;

    // The byte being written now is the final one of the payload.
    assign w_last_wr = (w_wr_ptr == (r_len - LEN_W'(1)));

    // In PAYLOAD the read pointer is one past the byte on data_in, so
    // reaching len means the byte on data_in is the last one.
    assign w_last_rd = (w_rd_ptr == r_len);

    // Step the read pointer whenever a header or non-final payload byte is
    // consumed, so the buffer has the next byte ready on that same edge.
    assign w_rd_inc = !busy &&
                      (((r_state == ST_HEADER) && (r_len != LEN_W'(0))) ||
                       ((r_state == ST_PAYLOAD) && !w_last_rd));

`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    assign w_parity_out = r_parity ^ {DATA_W{r_inject}};
`else
    assign w_parity_out = r_parity;
`endif

    router_tx_buf u_buf (
        .clock     (clock),
        .reset     (reset),
        .i_clr     (w_accept),
        .i_wr_en   (w_wr_en),
        .i_wr_data (pl_data),
        .i_rd_inc  (w_rd_inc),
        .o_wr_ptr  (w_wr_ptr),
        .o_rd_ptr  (w_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Handshake readies decode from the state register only.
    always_comb begin
        req_ready = 1'b0;
        pl_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                pl_ready  = 1'b0;
            end
            ST_LOAD: begin
                req_ready = 1'b0;
                pl_ready  = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
                pl_ready  = 1'b0;
            end
        endcase
    end

    // Transmit FSM with registered router-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= {ADDR_W{1'b0}};
            r_len       <= {LEN_W{1'b0}};
            r_parity    <= {DATA_W{1'b0}};
            r_gap_cnt   <= 4'd0;
            r_pkt_valid <= 1'b0;
            r_data_in   <= {DATA_W{1'b0}};
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
            r_inject    <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_len       <= req_len;
                        r_parity    <= hdr_pack(req_len, req_addr);
                        r_tx_active <= 1'b1;
                        r_gap_cnt   <= 4'd0;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
                        r_inject    <= inject_err;
`endif
                        if (req_len != LEN_W'(0)) begin
                            r_state <= ST_LOAD;
                        end else begin
                            // Nothing to buffer: header goes out immediately.
                            r_state     <= ST_HEADER;
                            r_pkt_valid <= 1'b1;
                            r_data_in   <= hdr_pack(req_len, req_addr);
                        end
                    end
                end
                ST_LOAD: begin
                    if (pl_valid) begin
                        r_parity <= parity_update(r_parity, pl_data);
                        if (w_last_wr) begin
                            r_state     <= ST_HEADER;
                            r_pkt_valid <= 1'b1;
                            r_data_in   <= hdr_pack(r_len, r_addr);
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        if (r_len != LEN_W'(0)) begin
                            r_state   <= ST_PAYLOAD;
                            r_data_in <= w_rd_data;
                        end else begin
                            r_state     <= ST_PARITY;
                            r_pkt_valid <= 1'b0;
                            r_data_in   <= w_parity_out;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        if (w_last_rd) begin
                            r_state     <= ST_PARITY;
                            r_pkt_valid <= 1'b0;
                            r_data_in   <= w_parity_out;
                        end else begin
                            r_data_in <= w_rd_data;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        r_tx_done   <= 1'b1;
                        r_pkt_valid <= 1'b0;
                        r_data_in   <= {DATA_W{1'b0}};
                        r_gap_cnt   <= 4'd0;
                        if (GAP_VAL == 4'd0) begin
                            r_state     <= ST_IDLE;
                            r_tx_active <= 1'b0;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // The tx_done cycle is the first gap cycle; stay one
                    // extra so GAP_CYCLES full idle cycles follow it.
                    if (r_gap_cnt == GAP_VAL) begin
                        r_state     <= ST_IDLE;
                        r_tx_active <= 1'b0;
                        r_gap_cnt   <= 4'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_pkt_valid <= 1'b0;
                    r_data_in   <= {DATA_W{1'b0}};
                    r_tx_active <= 1'b0;
                end
            endcase
        end
    end

    assign pkt_valid = r_pkt_valid;
    assign data_in   = r_data_in;
    assign tx_active = r_tx_active;
    assign tx_done   = r_tx_done;

endmodule

// File: tb/tb_router_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_router_pkt_tx
// Directed self-checking bench for router_pkt_tx (GAP_CYCLES = 3).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_addr;
    logic [5:0] req_len;
    logic       req_ready;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       tx_active;
    logic       tx_done;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    logic       inject_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] pl_buf  [0:63];
    logic       sched   [0:63];
    logic [7:0] cap_d   [0:63];
    logic       cap_pv  [0:63];
    logic       cap_done[0:63];
    logic       cap_rr  [0:63];
    logic       cap_plr [0:63];
    logic       cap_act [0:63];

    always #5 clock = ~clock;

    router_pkt_tx #(.GAP_CYCLES(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .pl_valid  (pl_valid),
        .pl_data   (pl_data),
        .pl_ready  (pl_ready),
        .busy      (busy),
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        .inject_err(inject_err),
`endif
        .pkt_valid (pkt_valid),
        .data_in   (data_in),
        .tx_active (tx_active),
        .tx_done   (tx_done)
    );

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) sched[i] = 1'b0;
    endtask

    // Issue a request and stream pl_buf[0..len-1]; returns at the negedge
    // after the last payload byte (or the request) is accepted.
    task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len);
        int wait_cnt;
        wait_cnt = 0;
        while (req_ready !== 1'b1 && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        if (wait_cnt >= 50) begin
            n_checks++;
            $display("FAIL send_pkt req_ready timeout: got %b want 1", req_ready);
        end
        req_valid = 1'b1;
        req_addr  = addr;
        req_len   = len;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            pl_valid = 1'b1;
            pl_data  = pl_buf[i];
            wait_cnt = 0;
            while (pl_ready !== 1'b1 && wait_cnt < 50) begin
                step();
                wait_cnt++;
            end
            if (wait_cnt >= 50) begin
                n_checks++;
                $display("FAIL send_pkt pl_ready timeout: got %b want 1", pl_ready);
            end
            step();
        end
        pl_valid = 1'b0;
        pl_data  = 8'hEE;
    endtask

    // Record n samples of the router side, driving busy from sched[].
    task automatic capture(input int n);
        for (int c = 0; c < n; c++) begin
            cap_d[c]    = data_in;
            cap_pv[c]   = pkt_valid;
            cap_done[c] = tx_done;
            cap_rr[c]   = req_ready;
            cap_plr[c]  = pl_ready;
            cap_act[c]  = tx_active;
            busy = sched[c];
            step();
        end
        busy = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", req_ready); else n_pass++;
        n_checks++; if (pl_ready !== 1'b0) $display("FAIL reset pl_ready: got %b want 0", pl_ready); else n_pass++;
        n_checks++; if (pkt_valid !== 1'b0) $display("FAIL reset pkt_valid: got %b want 0", pkt_valid); else n_pass++;
        n_checks++; if (data_in !== 8'h00) $display("FAIL reset data_in: got %h want 00", data_in); else n_pass++;
        n_checks++; if (tx_done !== 1'b0) $display("FAIL reset tx_done: got %b want 0", tx_done); else n_pass++;
        n_checks++; if (tx_active !== 1'b0) $display("FAIL reset tx_active: got %b want 0", tx_active); else n_pass++;
    endtask

    task automatic test_nominal();
        int done_cnt;
        for (int i = 0; i < 16; i++) pl_buf[i] = 8'(i + 1);
        clear_sched();
        send_pkt(2'd1, 6'd16);
        capture(24);
        n_checks++; if (cap_d[0] !== 8'h41 || cap_pv[0] !== 1'b1) $display("FAIL nominal header: got %h/%b want 41/1", cap_d[0], cap_pv[0]); else n_pass++;
        n_checks++; if (cap_plr[0] !== 1'b0) $display("FAIL nominal pl_ready after load: got %b want 0", cap_plr[0]); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (cap_d[i+1] !== 8'(i + 1) || cap_pv[i+1] !== 1'b1)
                $display("FAIL nominal payload[%0d]: got %h/%b want %h/1", i, cap_d[i+1], cap_pv[i+1], 8'(i + 1));
            else n_pass++;
        end
        n_checks++; if (cap_d[17] !== 8'h51 || cap_pv[17] !== 1'b0) $display("FAIL nominal parity: got %h/%b want 51/0", cap_d[17], cap_pv[17]); else n_pass++;
        n_checks++; if (cap_done[18] !== 1'b1) $display("FAIL nominal tx_done position: got %b want 1", cap_done[18]); else n_pass++;
        done_cnt = 0;
        for (int c = 0; c < 24; c++) if (cap_done[c] === 1'b1) done_cnt++;
        n_checks++; if (done_cnt != 1) $display("FAIL nominal tx_done count: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (cap_d[18] !== 8'h00) $display("FAIL nominal gap data_in: got %h want 00", cap_d[18]); else n_pass++;
        for (int c = 18; c < 22; c++) begin
            n_checks++;
            if (cap_rr[c] !== 1'b0) $display("FAIL nominal gap req_ready[%0d]: got %b want 0", c, cap_rr[c]); else n_pass++;
        end
        n_checks++; if (cap_rr[22] !== 1'b1) $display("FAIL nominal req_ready after gap: got %b want 1", cap_rr[22]); else n_pass++;
        n_checks++; if (cap_act[21] !== 1'b1 || cap_act[22] !== 1'b0) $display("FAIL nominal tx_active end: got %b%b want 10", cap_act[21], cap_act[22]); else n_pass++;
    endtask

    task automatic test_busy_stall();
        for (int i = 0; i < 16; i++) pl_buf[i] = 8'(i + 1);
        clear_sched();
        sched[5] = 1'b1;
        sched[6] = 1'b1;
        sched[7] = 1'b1;
        sched[22] = 1'b1;  // busy during the gap must not stretch it
        busy = 1'b1;       // busy during load must not stall buffering
        send_pkt(2'd1, 6'd16);
        capture(26);
        n_checks++; if (cap_d[0] !== 8'h41) $display("FAIL stall header: got %h want 41", cap_d[0]); else n_pass++;
        n_checks++; if (cap_d[4] !== 8'h04) $display("FAIL stall byte before hold: got %h want 04", cap_d[4]); else n_pass++;
        for (int c = 5; c < 9; c++) begin
            n_checks++;
            if (cap_d[c] !== 8'h05 || cap_pv[c] !== 1'b1) $display("FAIL stall hold[%0d]: got %h/%b want 05/1", c, cap_d[c], cap_pv[c]); else n_pass++;
        end
        n_checks++; if (cap_d[9] !== 8'h06) $display("FAIL stall next byte: got %h want 06", cap_d[9]); else n_pass++;
        n_checks++; if (cap_d[19] !== 8'h10) $display("FAIL stall last byte: got %h want 10", cap_d[19]); else n_pass++;
        n_checks++; if (cap_d[20] !== 8'h51 || cap_pv[20] !== 1'b0) $display("FAIL stall parity: got %h/%b want 51/0", cap_d[20], cap_pv[20]); else n_pass++;
        n_checks++; if (cap_done[21] !== 1'b1) $display("FAIL stall tx_done: got %b want 1", cap_done[21]); else n_pass++;
        n_checks++; if (cap_rr[24] !== 1'b0 || cap_rr[25] !== 1'b1) $display("FAIL stall gap length: got %b%b want 01", cap_rr[24], cap_rr[25]); else n_pass++;
    endtask

    task automatic test_zero_len();
        int plr_cnt;
        clear_sched();
        send_pkt(2'd2, 6'd0);
        capture(8);
        n_checks++; if (cap_d[0] !== 8'h02 || cap_pv[0] !== 1'b1) $display("FAIL zero_len header: got %h/%b want 02/1", cap_d[0], cap_pv[0]); else n_pass++;
        n_checks++; if (cap_rr[0] !== 1'b0) $display("FAIL zero_len req_ready while sending: got %b want 0", cap_rr[0]); else n_pass++;
        n_checks++; if (cap_d[1] !== 8'h02 || cap_pv[1] !== 1'b0) $display("FAIL zero_len parity: got %h/%b want 02/0", cap_d[1], cap_pv[1]); else n_pass++;
        n_checks++; if (cap_done[2] !== 1'b1) $display("FAIL zero_len tx_done: got %b want 1", cap_done[2]); else n_pass++;
        plr_cnt = 0;
        for (int c = 0; c < 8; c++) if (cap_plr[c] !== 1'b0) plr_cnt++;
        n_checks++; if (plr_cnt != 0) $display("FAIL zero_len pl_ready asserted: got %0d cycles want 0", plr_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_sched();
        pl_buf[0] = 8'h7F;
        send_pkt(2'd0, 6'd1);
        capture(8);
        n_checks++; if (cap_d[0] !== 8'h04 || cap_d[1] !== 8'h7F) $display("FAIL b2b first hdr/byte: got %h %h want 04 7f", cap_d[0], cap_d[1]); else n_pass++;
        n_checks++; if (cap_d[2] !== 8'h7B || cap_done[3] !== 1'b1) $display("FAIL b2b first parity/done: got %h %b want 7b 1", cap_d[2], cap_done[3]); else n_pass++;
        n_checks++;
        if (cap_rr[3] !== 1'b0 || cap_rr[4] !== 1'b0 || cap_rr[5] !== 1'b0 || cap_rr[6] !== 1'b0 || cap_rr[7] !== 1'b1)
            $display("FAIL b2b req_ready gap: got %b%b%b%b%b want 00001", cap_rr[3], cap_rr[4], cap_rr[5], cap_rr[6], cap_rr[7]);
        else n_pass++;
        pl_buf[0] = 8'hAA;
        pl_buf[1] = 8'hBB;
        pl_buf[2] = 8'hCC;
        send_pkt(2'd2, 6'd3);
        capture(6);
        n_checks++; if (cap_d[0] !== 8'h0E || cap_pv[0] !== 1'b1) $display("FAIL b2b second header: got %h/%b want 0e/1", cap_d[0], cap_pv[0]); else n_pass++;
        n_checks++; if (cap_d[1] !== 8'hAA || cap_d[2] !== 8'hBB || cap_d[3] !== 8'hCC) $display("FAIL b2b second payload: got %h %h %h want aa bb cc", cap_d[1], cap_d[2], cap_d[3]); else n_pass++;
        n_checks++; if (cap_d[4] !== 8'hD3 || cap_pv[4] !== 1'b0) $display("FAIL b2b second parity: got %h/%b want d3/0", cap_d[4], cap_pv[4]); else n_pass++;
        repeat (6) step();
    endtask

    task automatic test_reset_mid();
        logic found;
        int   stray;
        for (int i = 0; i < 16; i++) pl_buf[i] = 8'(i + 1);
        busy = 1'b0;
        send_pkt(2'd1, 6'd16);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (data_in === 8'h08) found = 1'b1;
            else step();
        end
        n_checks++; if (!found || pkt_valid !== 1'b1) $display("FAIL reset_mid reach byte 8: got %h/%b want 08/1", data_in, pkt_valid); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (pkt_valid !== 1'b0) $display("FAIL reset_mid pkt_valid: got %b want 0", pkt_valid); else n_pass++;
        n_checks++; if (data_in !== 8'h00) $display("FAIL reset_mid data_in: got %h want 00", data_in); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_mid idle req_ready: got %b want 1", req_ready); else n_pass++;
        n_checks++; if (tx_active !== 1'b0) $display("FAIL reset_mid tx_active: got %b want 0", tx_active); else n_pass++;
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            if (pkt_valid !== 1'b0 || data_in !== 8'h00 || tx_done !== 1'b0) stray++;
            step();
        end
        n_checks++; if (stray != 0) $display("FAIL reset_mid abandoned packet output: got %0d cycles want 0", stray); else n_pass++;
    endtask

`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
    task automatic test_err_inject();
        for (int i = 0; i < 16; i++) pl_buf[i] = 8'(i + 1);
        clear_sched();
        inject_err = 1'b1;
        send_pkt(2'd1, 6'd16);
        inject_err = 1'b0;
        capture(24);
        n_checks++; if (cap_d[0] !== 8'h41) $display("FAIL inject header: got %h want 41", cap_d[0]); else n_pass++;
        n_checks++; if (cap_d[17] !== 8'hAE || cap_pv[17] !== 1'b0) $display("FAIL inject parity: got %h/%b want ae/0", cap_d[17], cap_pv[17]); else n_pass++;
        send_pkt(2'd1, 6'd16);
        capture(24);
        n_checks++; if (cap_d[17] !== 8'h51) $display("FAIL inject cleared parity: got %h want 51", cap_d[17]); else n_pass++;
    endtask
`endif

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 2'd0;
        req_len   = 6'd0;
        pl_valid  = 1'b0;
        pl_data   = 8'h00;
        busy      = 1'b0;
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        inject_err = 1'b0;
`endif
        clear_sched();
        test_reset();
        test_nominal();
        test_busy_stall();
        test_back_to_back();
        test_reset_mid();
        test_zero_len();
`ifdef ROUTER_PKT_TX_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
